// File: rtl/ps2_key_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_encoder
//  Description : Debounces a parallel button panel and emits ps2_key events
//                {toggle, pressed, code[8:0]}, one per accepted change.
//  Revision    : 1.0
// ============================================================================
module ps2_key_encoder #(
    parameter int NUM_BTN         = 8,
    parameter int DEBOUNCE_CYCLES = 9987,
    parameter int GAP             = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_BTN-1:0]   I_BTN,
    input  logic [9*NUM_BTN-1:0] I_CODE_TAB,
    input  logic                 I_EN,
    output logic [10:0]          O_PS2_KEY,
    output logic                 O_BUSY
);

    localparam int c_IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
    localparam int c_PRE_W = $clog2(DEBOUNCE_CYCLES);
    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_BTN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer, prescaler and per-button debounce
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] meta_q;
    logic [NUM_BTN-1:0] sync_q;
    logic [c_PRE_W-1:0] presc_q;
    logic [NUM_BTN-1:0] deb_q;
    logic [1:0]         cnt_q [NUM_BTN];
    logic               w_tick;

    assign w_tick = (presc_q == c_PRE_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            meta_q  <= '0;
            sync_q  <= '0;
            presc_q <= '0;
        end else begin
            meta_q  <= I_BTN;
            sync_q  <= meta_q;
            presc_q <= w_tick ? '0 : presc_q + c_PRE_W'(1);
        end
    end

    // A level must disagree with deb on three consecutive ticks to be taken.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            deb_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync_q[i] == deb_q[i]) begin
                    cnt_q[i] <= 2'd0;
                end else if (cnt_q[i] == 2'd2) begin
                    deb_q[i] <= sync_q[i];
                    cnt_q[i] <= 2'd0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending set and round-robin search
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] rep_q, rep_d;
    logic [NUM_BTN-1:0] w_pend;
    logic [c_IDX_W-1:0] rr_q, rr_d;
    logic [c_IDX_W-1:0] sel_q, sel_d;
    logic [c_IDX_W-1:0] w_sel;
    logic               w_found;
    int                 w_j;

    assign w_pend = deb_q ^ rep_q;
    assign O_BUSY = |w_pend;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_j     = 0;
        for (int k = 0; k < NUM_BTN; k++) begin
            w_j = int'(rr_q) + k;
            if (w_j >= NUM_BTN) begin
                w_j = w_j - NUM_BTN;
            end
            if (!w_found && w_pend[w_j]) begin
                w_found = 1'b1;
                w_sel   = c_IDX_W'(w_j);
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FSM
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [c_GAP_W-1:0] gap_q, gap_d;
    logic [10:0]        key_q, key_d;

    assign O_PS2_KEY = key_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            key_q   <= '0;
            rep_q   <= '0;
            rr_q    <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            key_q   <= key_d;
            rep_q   <= rep_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        key_d   = key_q;
        rep_d   = rep_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (I_EN && (|w_pend)) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_found) begin
                    sel_d   = w_sel;
                    state_d = S_EMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                // A change that reverted since SCAN is dropped rather than sent.
                if (w_pend[sel_q]) begin
                    key_d        = {~key_q[10], deb_q[sel_q],
                                    I_CODE_TAB[int'(sel_q)*9 +: 9]};
                    rep_d[sel_q] = deb_q[sel_q];
                end
                rr_d    = (sel_q == c_IDX_LAST) ? '0 : sel_q + c_IDX_W'(1);
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + c_GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
